// File: rtl/getir_paket.sv
// getir_paket: shared definitions for the fetch-stage controller.
//   - getir_durum_e        : controller states (SIFIR, ISTE, TUT, IPTAL)
//   - NOP_BUYRUK           : bubble instruction, addi x0,x0,0
//   - BASLANGIC_ADRES_VARS : default PC after reset
//   - sunum_t              : one presented {instruction, valid, pc} triple
//   - hizala()             : clears the two low address bits of a redirect target
package getir_paket;

  typedef enum logic [1:0] {
    SIFIR = 2'd0,
    ISTE  = 2'd1,
    TUT   = 2'd2,
    IPTAL = 2'd3
  } getir_durum_e;

  localparam logic [31:0] NOP_BUYRUK           = 32'h0000_0013;
  localparam logic [31:0] BASLANGIC_ADRES_VARS = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] buyruk;
    logic        gecerli;
    logic [31:0] ps;
  } sunum_t;

  function automatic logic [31:0] hizala(input logic [31:0] adres);
    return {adres[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/getir_sayaclari.sv
// getir_sayaclari: stall and flush event counters for the fetch controller.
// Ports:
//   clk_i, rst_i    : clock, synchronous active-high reset
//   durdur_i        : decode stall, counted every cycle it is high
//   dallan_i        : redirect/flush, counted every cycle it is high
//   durdur_sayac_o  : number of stall cycles, wraps at 2^32
//   iptal_sayac_o   : number of flush cycles, wraps at 2^32
module getir_sayaclari (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        durdur_i,
  input  logic        dallan_i,
  output logic [31:0] durdur_sayac_o,
  output logic [31:0] iptal_sayac_o
);

  logic [31:0] durdur_q, durdur_d;
  logic [31:0] iptal_q, iptal_d;

  always_comb begin
    durdur_d = durdur_q + {31'd0, durdur_i};
    iptal_d  = iptal_q + {31'd0, dallan_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durdur_q <= 32'd0;
      iptal_q  <= 32'd0;
    end else begin
      durdur_q <= durdur_d;
      iptal_q  <= iptal_d;
    end
  end

  assign durdur_sayac_o = durdur_q;
  assign iptal_sayac_o  = iptal_q;

endmodule

// File: rtl/getir_denetleyici.sv
// getir_denetleyici: fetch-stage controller feeding the fetch/decode register.
// Owns the PC, runs a single-outstanding request handshake to instruction
// memory and produces the next value of the gc register every cycle. Stalls
// re-present the last value, flushes present a NOP, and one response that
// lands during a stall is buffered until the stall releases.
// Ports:
//   clk_i, rst_i                     : clock, synchronous active-high reset
//   bellek_istek_o / bellek_adres_o  : memory request valid / address
//   bellek_hazir_i / bellek_buyruk_i : memory response valid / data
//   durdur_i                         : decode stall
//   dallan_i / dallan_adres_i        : redirect and its target
//   buyruk_o / buyruk_gecerli_o / ps_o : gc register next value, valid, pc
// Optional feature: define GETIR_SAYAC_EN to add durdur_sayac_o and
// iptal_sayac_o (stall / flush cycle counters).
module getir_denetleyici
  import getir_paket::*;
#(
  parameter logic [31:0] BASLANGIC_ADRES = BASLANGIC_ADRES_VARS
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        bellek_istek_o,
  output logic [31:0] bellek_adres_o,
  input  logic        bellek_hazir_i,
  input  logic [31:0] bellek_buyruk_i,
  input  logic        durdur_i,
  input  logic        dallan_i,
  input  logic [31:0] dallan_adres_i,
  output logic [31:0] buyruk_o,
  output logic        buyruk_gecerli_o,
  output logic [31:0] ps_o
`ifdef GETIR_SAYAC_EN
  ,
  output logic [31:0] durdur_sayac_o,
  output logic [31:0] iptal_sayac_o
`endif
);

  getir_durum_e durum_q, durum_d;
  logic [31:0]  ps_q, ps_d;
  logic [31:0]  hedef_q, hedef_d;
  sunum_t       son_q;
  sunum_t       tampon_q, tampon_d;
  sunum_t       sunum;
  logic [31:0]  ps_arti4;
  logic [31:0]  dal_hedef;

  assign ps_arti4  = ps_q + 32'd4;
  assign dal_hedef = hizala(dallan_adres_i);

  always_comb begin
    durum_d        = durum_q;
    ps_d           = ps_q;
    hedef_d        = hedef_q;
    tampon_d       = tampon_q;
    bellek_istek_o = 1'b0;
    sunum          = '{buyruk: NOP_BUYRUK, gecerli: 1'b0, ps: ps_q};

    unique case (durum_q)
      SIFIR: begin
        // Any late response from a request abandoned by reset is ignored here.
        durum_d = ISTE;
      end

      ISTE: begin
        bellek_istek_o = 1'b1;
        if (dallan_i) begin
          if (bellek_hazir_i) begin
            ps_d = dal_hedef;
          end else begin
            // Request must stay on the bus at the old address until it completes.
            hedef_d = dal_hedef;
            durum_d = IPTAL;
          end
        end else if (bellek_hazir_i) begin
          ps_d = ps_arti4;
          if (durdur_i) begin
            tampon_d = '{buyruk: bellek_buyruk_i, gecerli: 1'b1, ps: ps_q};
            sunum    = son_q;
            durum_d  = TUT;
          end else begin
            sunum = '{buyruk: bellek_buyruk_i, gecerli: 1'b1, ps: ps_q};
          end
        end else if (durdur_i) begin
          sunum = son_q;
        end
      end

      TUT: begin
        if (dallan_i) begin
          ps_d    = dal_hedef;
          durum_d = ISTE;
        end else if (durdur_i) begin
          sunum = son_q;
        end else begin
          sunum   = tampon_q;
          durum_d = ISTE;
        end
      end

      IPTAL: begin
        bellek_istek_o = 1'b1;
        if (dallan_i) begin
          hedef_d = dal_hedef;
        end
        if (bellek_hazir_i) begin
          // A redirect in the completing cycle is the newest target.
          ps_d    = dallan_i ? dal_hedef : hedef_q;
          durum_d = ISTE;
        end
      end

      default: durum_d = SIFIR;
    endcase

    // Reset overrides everything combinationally so an in-flight request drops at once.
    if (rst_i) begin
      bellek_istek_o = 1'b0;
      sunum          = '{buyruk: NOP_BUYRUK, gecerli: 1'b0, ps: BASLANGIC_ADRES};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q  <= SIFIR;
      ps_q     <= BASLANGIC_ADRES;
      hedef_q  <= BASLANGIC_ADRES;
      son_q    <= '{buyruk: NOP_BUYRUK, gecerli: 1'b0, ps: BASLANGIC_ADRES};
      tampon_q <= '{buyruk: NOP_BUYRUK, gecerli: 1'b0, ps: BASLANGIC_ADRES};
    end else begin
      durum_q  <= durum_d;
      ps_q     <= ps_d;
      hedef_q  <= hedef_d;
      son_q    <= sunum;
      tampon_q <= tampon_d;
    end
  end

  assign bellek_adres_o   = rst_i ? BASLANGIC_ADRES : ps_q;
  assign buyruk_o         = sunum.buyruk;
  assign buyruk_gecerli_o = sunum.gecerli;
  assign ps_o             = sunum.ps;

`ifdef GETIR_SAYAC_EN
  getir_sayaclari u_sayaclar (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .durdur_i       (durdur_i),
    .dallan_i       (dallan_i),
    .durdur_sayac_o (durdur_sayac_o),
    .iptal_sayac_o  (iptal_sayac_o)
  );
`endif

endmodule
